avmm_word_master: RTL

- Avalon-MM master engine that drives the slave side of the board/control RAM block: sequential word reads and writes over a 15-bit word address space.
- A command port starts a transfer of N consecutive words from a base address.
- Write data enters on a valid/ready stream; read data leaves on a valid/ready stream.
- Sits between HPS/search logic and the control slave; the engine issues the same traffic the control slave's bench drives by hand.

---
 rtl/avmm_pkg.sv | 27 ++
 rtl/avmm_xfer_counter.sv | 44 ++++
 rtl/avmm_word_master.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/avmm_pkg.sv
// ============================================================================
// Module      : avmm_pkg
// Description : Shared types and defaults for the Avalon-MM word master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avmm_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 15;

    localparam logic [DEF_DATA_WIDTH/8-1:0] BE_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FETCH = 3'd1,
        ST_WR_ISSUE = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_PUSH  = 3'd5,
        ST_FINISH   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/avmm_xfer_counter.sv
// ============================================================================
// Module      : avmm_xfer_counter
// Description : Loadable word address (wrapping) and remaining-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_xfer_counter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [ADDR_WIDTH-1:0]  i_base,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_step,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic                   o_last
);

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [COUNT_WIDTH-1:0] r_remaining;

    // Address wraps naturally at 2^ADDR_WIDTH through truncation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_count;
        end else if (i_step) begin
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == COUNT_WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/avmm_word_master.sv
// ============================================================================
// Module      : avmm_word_master
// Description : Avalon-MM master moving N sequential words between streams and
//               a word-addressed slave. Optional watchdog: AVMM_WORD_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_word_master
    import avmm_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [COUNT_WIDTH-1:0]  cmd_count,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_read,
    output logic                    master_write,
    output logic [DATA_WIDTH-1:0]   master_writedata,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    input  logic                    master_waitrequest,
    input  logic                    master_readdatavalid
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;
    logic                  w_step;
    logic                  w_leave;
    logic                  w_last;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_accept = (r_state == ST_IDLE) && cmd_start;
    assign w_step   = ((r_state == ST_WR_ISSUE) && !master_waitrequest) ||
                      ((r_state == ST_RD_PUSH)  && rd_ready);

    // Condition under which the current state is left on the next edge.
    always_comb begin
        w_leave = 1'b1;
        case (r_state)
            ST_IDLE:     w_leave = cmd_start;
            ST_WR_FETCH: w_leave = wr_valid;
            ST_WR_ISSUE: w_leave = !master_waitrequest;
            ST_RD_ISSUE: w_leave = !master_waitrequest;
            ST_RD_WAIT:  w_leave = master_readdatavalid;
            ST_RD_PUSH:  w_leave = rd_ready;
            default:     w_leave = 1'b1;
        endcase
    end

    avmm_xfer_counter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_base  (cmd_base),
        .i_count (cmd_count),
        .i_step  (w_step),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_count == '0)
                            r_state <= ST_FINISH;
                        else if (cmd_write)
                            r_state <= ST_WR_FETCH;
                        else
                            r_state <= ST_RD_ISSUE;
                    end
                end
                ST_WR_FETCH: begin
                    if (wr_valid) begin
                        r_wdata <= wr_data;
                        r_state <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    if (!master_waitrequest)
                        r_state <= w_last ? ST_FINISH : ST_WR_FETCH;
                    else if (w_timeout)
                        r_state <= ST_FINISH;
                end
                ST_RD_ISSUE: begin
                    if (!master_waitrequest) begin
                        // Zero-latency slaves may return data in the accept cycle.
                        if (master_readdatavalid) begin
                            r_rdata <= master_readdata;
                            r_state <= ST_RD_PUSH;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        r_rdata <= master_readdata;
                        r_state <= ST_RD_PUSH;
                    end else if (w_timeout) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_RD_PUSH: begin
                    if (rd_ready)
                        r_state <= w_last ? ST_FINISH : ST_RD_ISSUE;
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AVMM_WORD_MASTER_TIMEOUT_EN
    localparam int c_WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_error;

    // Only bus-side waits are guarded; stream stalls may last indefinitely.
    assign w_timeout = ((r_state == ST_WR_ISSUE) || (r_state == ST_RD_ISSUE) ||
                        (r_state == ST_RD_WAIT)) && !w_leave &&
                       (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_leave || w_timeout)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;
            if (w_accept)
                r_error <= 1'b0;
            else if (w_timeout)
                r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    generate
        if (DATA_WIDTH == DEF_DATA_WIDTH) begin : g_be_default
            assign master_byteenable = BE_ALL_ONES;
        end else begin : g_be_generic
            assign master_byteenable = '1;
        end
    endgenerate

    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_FINISH);
    assign wr_ready         = (r_state == ST_WR_FETCH);
    assign rd_valid         = (r_state == ST_RD_PUSH);
    assign rd_data          = r_rdata;
    assign master_address   = w_addr;
    assign master_read      = (r_state == ST_RD_ISSUE);
    assign master_write     = (r_state == ST_WR_ISSUE);
    assign master_writedata = r_wdata;

endmodule

`default_nettype wire
